// File: rtl/fixed_pkg.sv
// Shared fixed-point helpers: stream FSM states, rescale shift and a generic
// round/saturate routine usable by any fixed-point block.
package fixed_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    RESULT = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  // Wide enough for a 64-bit product plus rounding carry and left shifts.
  localparam int RS_W = 128;

  typedef struct packed {
    logic [RS_W-1:0] val;
    logic            sat;
  } rs_t;

  // Right-shift needed to move a product of two fixed-point operands
  // into the output fraction format (negative means shift left).
  function automatic int shift_amt(input int a_frac, input int b_frac,
                                   input int out_frac);
    return a_frac + b_frac - out_frac;
  endfunction

  // Round half toward +inf, then clamp to a signed out_w-bit range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] p,
                                    input int sh, input int out_w);
    logic signed [RS_W-1:0] r, hi, lo, one;
    rs_t o;
    one = 1;
    if (sh > 0)      r = (p + (one <<< (sh - 1))) >>> sh;
    else if (sh < 0) r = p <<< (-sh);
    else             r = p;
    hi    = (one <<< (out_w - 1)) - one;
    lo    = -hi - one;
    o.sat = (r > hi) || (r < lo);
    o.val = (r > hi) ? hi : ((r < lo) ? lo : r);
    return o;
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational rescale of a full product: round, saturate, flag overflow.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int SH        = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic signed [IN_WIDTH-1:0]  prod,
  output logic        [OUT_WIDTH-1:0] res,
  output logic                        sat
);

  rs_t  rs;
  logic unused_hi;

  // Sign-extend into the helper's working width and rescale.
  always_comb begin
    rs = round_sat(RS_W'(prod), SH, OUT_WIDTH);
  end

  // Upper bits are only copies of the sign after clamping.
  assign res       = rs.val[OUT_WIDTH-1:0];
  assign sat       = rs.sat;
  assign unused_hi = ^rs.val[RS_W-1:OUT_WIDTH];

endmodule

// File: rtl/fixed_mul_stream.sv
// Streaming signed fixed-point multiplier feeding an accumulator.
// Two-stage pipeline (product, then round/sat) and a per-vector
// sequencer: RUN -> DRAIN (2 cycles) -> RESULT -> CLEAR -> RUN.
module fixed_mul_stream
  import fixed_pkg::*;
#(
  parameter int A_WIDTH   = 32,
  parameter int A_FRAC    = 16,
  parameter int B_WIDTH   = 32,
  parameter int B_FRAC    = 16,
  parameter int OUT_WIDTH = 32,
  parameter int OUT_FRAC  = 16,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [A_WIDTH-1:0]   s_a,
  input  logic [B_WIDTH-1:0]   s_b,
  input  logic                 s_last,
  output logic [OUT_WIDTH-1:0] acc_a,
  output logic                 acc_nd,
  output logic                 acc_done,
  output logic                 result_valid,
  input  logic                 result_ack,
  output logic [LEN_WIDTH-1:0] result_len,
  output logic                 sat_flag
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int SH      = shift_amt(A_FRAC, B_FRAC, OUT_FRAC);

  state_t                state, state_nx;
  logic                  drain_cnt;
  logic                  accept;
  logic [2:1]            vld_pipe;
  logic signed [P_WIDTH-1:0] a_ext, b_ext, prod;
  logic [OUT_WIDTH-1:0]  rs_val;
  logic                  rs_sat;
  logic [LEN_WIDTH-1:0]  cnt;
  logic                  sat_q;

  assign accept = s_valid && s_ready;
  assign a_ext  = P_WIDTH'(signed'(s_a));
  assign b_ext  = P_WIDTH'(signed'(s_b));

  // State register; reset lands in CLEAR so the accumulator is re-zeroed.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nx;
  end

  // DRAIN cycle counter: 0 on the first DRAIN cycle, 1 on the second.
  always_ff @(posedge clk) begin
    if (rst)                 drain_cnt <= 1'b0;
    else if (state == DRAIN) drain_cnt <= ~drain_cnt;
    else                     drain_cnt <= 1'b0;
  end

  // Next-state logic. A last beat taken in CLEAR closes a one-beat vector.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (accept && s_last) state_nx = DRAIN;
      DRAIN:   if (drain_cnt)        state_nx = RESULT;
      RESULT:  if (result_ack)       state_nx = CLEAR;
      CLEAR:   state_nx = (accept && s_last) ? DRAIN : RUN;
      default: state_nx = CLEAR;
    endcase
  end

  // Moore outputs.
  always_comb begin
    s_ready      = (state == RUN) || (state == CLEAR);
    result_valid = (state == RESULT);
    acc_done     = (state == CLEAR);
  end

  fixed_round_sat #(
    .IN_WIDTH  (P_WIDTH),
    .SH        (SH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .prod (prod),
    .res  (rs_val),
    .sat  (rs_sat)
  );

  // Fixed-latency datapath: stage 1 holds the product, stage 2 the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      prod     <= '0;
      acc_a    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], accept};
      if (accept)      prod  <= a_ext * b_ext;
      if (vld_pipe[1]) acc_a <= rs_val;
    end
  end

  assign acc_nd = vld_pipe[2];

  // Beat counter and sticky saturation; CLEAR starts a fresh vector and
  // still counts a beat accepted in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sat_q <= 1'b0;
    end else if (state == CLEAR) begin
      cnt   <= LEN_WIDTH'(accept);
      sat_q <= 1'b0;
    end else begin
      if (accept && (cnt != '1)) cnt   <= cnt + 1'b1;
      if (vld_pipe[1] && rs_sat) sat_q <= 1'b1;
    end
  end

  assign result_len = cnt;
  assign sat_flag   = sat_q;

endmodule

// File: doc/fixed_mul_stream.md
Name: fixed_mul_stream

Overview:
- Streaming signed fixed-point multiplier; the upstream feeder of the fixed-point accumulator.
- Accepts operand pairs (a, b) over a valid/ready stream with a vector-end marker.
- Rescales each product to the accumulator input format with rounding and saturation, and drives the accumulator's nd/done controls.
- Sequences each vector: multiply, drain, present result, clear.

Parameters:
- A_WIDTH, 32, operand a width (signed two's complement)
- A_FRAC, 16, operand a fraction bits
- B_WIDTH, 32, operand b width (signed)
- B_FRAC, 16, operand b fraction bits
- OUT_WIDTH, 32, product width sent to accumulator (its IN_WIDTH)
- OUT_FRAC, 16, product fraction bits (its IN_FRAC)
- LEN_WIDTH, 16, element counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  operand beat valid
- s_ready  out  1  operand beat accepted when s_valid && s_ready
- s_a  in  A_WIDTH  operand a
- s_b  in  B_WIDTH  operand b
- s_last  in  1  final beat of vector
- acc_a  out  OUT_WIDTH  rescaled product to accumulator
- acc_nd  out  1  product valid, one cycle per beat
- acc_done  out  1  accumulator clear pulse
- result_valid  out  1  accumulator output holds completed vector sum
- result_ack  in  1  consumer has read the sum
- result_len  out  LEN_WIDTH  beats in completed vector
- sat_flag  out  1  any product in the vector saturated

Behaviour:
- Reset: one clock (clk); synchronous, active-high reset (rst). Forces state CLEAR and clears both pipeline valid bits, counter and sat flag.
- Reset values:
  - s_ready=1, acc_nd=0, acc_a=0, result_valid=0, result_len=0, sat_flag=0.
  - acc_done=1 (Moore decode of CLEAR), so the accumulator is cleared in the first cycle after reset.
- Arithmetic:
  - Full product P = a*b, signed, A_WIDTH+B_WIDTH bits, frac A_FRAC+B_FRAC.
  - SH = A_FRAC+B_FRAC-OUT_FRAC.
  - SH>0: add 1<<(SH-1), then arithmetic shift right by SH (round half toward +inf).
  - SH<0: shift left by -SH. SH=0: pass through.
  - Saturate to signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; a saturating beat sets the sticky sat_flag.
  - Intermediate width must hold the rounding carry without overflow.
- Pipeline:
  - Stage 1 registers P. Stage 2 registers round/sat into acc_a.
  - acc_nd is asserted in cycle T+2 for a beat accepted in cycle T.
  - Fixed latency; no internal backpressure, because the accumulator cannot stall.
- FSM states:
  - RUN: s_ready=1. Each accepted beat increments the counter (saturating at all-ones). An accepted beat with s_last -> DRAIN.
  - DRAIN: s_ready=0. Lasts exactly 2 cycles (last product reaches acc_nd, accumulator registers it) -> RESULT.
  - RESULT: s_ready=0, result_valid=1; result_len and sat_flag are stable. On result_ack -> CLEAR. result_ack is ignored outside RESULT.
  - CLEAR: acc_done=1 for exactly one cycle; counter and sat_flag are zeroed -> RUN.
- CLEAR s_ready: s_ready=1 in CLEAR. A beat accepted in CLEAR reaches acc_nd two cycles later, after done, so it is not lost. It counts toward the new vector.
- Timing: a last beat accepted at T gives result_valid from T+3. With result_ack held high, acc_done occurs at T+4 and RUN/s_ready=1 at T+5.
- acc_done and acc_nd are never asserted in the same cycle (the accumulator gives done priority).
- Single-beat vector (s_last on the first beat) is legal. Zero-length vectors do not exist.
- Reset mid-vector: in-flight beats are discarded (no acc_nd after reset) and the CLEAR pulse re-zeroes the accumulator.
- s_valid held with s_ready=0: the beat is not consumed, and s_a/s_b/s_last must be held stable by the source.

Decomposition:
- Shared package fixed_pkg holds:
  - the state enum (RUN, DRAIN, RESULT, CLEAR);
  - a localparam function for SH;
  - a round/saturate function reusable by other fixed-point blocks.
- One natural sub-module: fixed_round_sat (combinational rounding + saturation + sat bit), instantiated between stage 1 and stage 2.

Test Plan:
- Q16.16 single beat 0x00018000 x 0x00020000, last=1 -> acc_a=0x00030000 at T+2; result_valid at T+3; result_len=1, sat_flag=0.
- Vector [0x00018000, 0xFFFF8000] x [0x00020000, 0x00040000] -> acc_a 0x00030000 then 0xFFFE0000; result_len=2; acc_done pulse one cycle after result_ack.
- Rounding:
  - 0x00000001 x 0x00008000 -> acc_a=0x00000001.
  - 0xFFFFFFFF x 0x00008000 -> acc_a=0x00000000.
- Saturation:
  - 0x7FFF0000 x 0x7FFF0000 -> acc_a=0x7FFFFFFF, sat_flag=1.
  - 0x80000000 x 0x7FFF0000 -> acc_a=0x80000000.
- Backpressure: hold result_ack=0 for 10 cycles with s_valid=1 -> s_ready=0 and no acc_nd throughout. Ack -> acc_done, then the held beat is accepted (in CLEAR or RUN).
- Reset asserted one cycle after accepting a 3-beat vector's second beat -> no acc_nd after reset, acc_done=1 first cycle after release, result_valid=0, result_len=0.
